// File: rtl/rom_dump_uart_pkg.sv
// Shared definitions for the ROM dump path: chip widths, ASCII codes,
// dump FSM state encoding and the nibble-to-hex-character helper.
package rom_dump_uart_pkg;

  // 556PT5 (3604) and 556PT4 (3601) reader widths
  localparam int IP3604_DATA_WIDTH    = 8;
  localparam int IP3604_ADDRESS_WIDTH = 9;
  localparam int IP3601_DATA_WIDTH    = 4;
  localparam int IP3601_ADDRESS_WIDTH = 8;

  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND    = 3'd3,
    ST_STEP_HI = 3'd4,
    ST_STEP_LO = 3'd5,
    ST_WAIT_TX = 3'd6
  } dump_state_e;

  // Uppercase ASCII hex digit for a 4-bit value
  function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
    logic [7:0] ch;
    if (nibble < 4'd10) begin
      ch = 8'h30 + {4'h0, nibble};
    end else begin
      ch = 8'h37 + {4'h0, nibble};
    end
    return ch;
  endfunction

endpackage

// File: rtl/rom_dump_uart_if.sv
// Link between the ROM reader and the dump stage: the reader presents
// address/data, the dump stage requests address steps.
interface rom_dump_uart_if #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 8
);
  logic [ADDRESS_WIDTH-1:0] address_line;
  logic [DATA_WIDTH-1:0]    data_line;
  logic                     increment_address;

  // Dump stage side: drives steps, samples the reader
  modport master (
    output increment_address,
    input  address_line,
    input  data_line
  );

  // Reader side
  modport slave (
    input  increment_address,
    output address_line,
    output data_line
  );
endinterface

// File: rtl/rom_dump_uart_tx.sv
// 8N1 UART serializer. Reports ready during the last cycle of the stop bit so
// a queued character starts immediately after a full-length stop bit.
module rom_dump_uart_tx #(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx
);
  localparam int DW = $clog2(DIV);
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [DW-1:0] STOP_LAST = DW'(DIV - 2);

  logic          active_r;
  logic          tx_r;
  logic [8:0]    shift_r;
  logic [3:0]    bit_idx_r;
  logic [DW-1:0] div_r;

  // Bit timing, shifting and handshake acceptance
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      active_r  <= 1'b0;
      tx_r      <= 1'b1;
      shift_r   <= 9'h1FF;
      bit_idx_r <= 4'd0;
      div_r     <= '0;
    end else if (active_r) begin
      if (bit_idx_r == 4'd9) begin
        if (div_r == STOP_LAST) begin
          active_r <= 1'b0;
          div_r    <= '0;
        end else begin
          div_r <= div_r + DW'(1'b1);
        end
      end else if (div_r == DIV_LAST) begin
        tx_r      <= shift_r[0];
        shift_r   <= {1'b0, shift_r[8:1]};
        bit_idx_r <= bit_idx_r + 4'd1;
        div_r     <= '0;
      end else begin
        div_r <= div_r + DW'(1'b1);
      end
    end else if (tx_valid) begin
      active_r  <= 1'b1;
      tx_r      <= 1'b0;
      shift_r   <= {1'b1, tx_data};
      bit_idx_r <= 4'd0;
      div_r     <= '0;
    end else begin
      tx_r <= 1'b1;
    end
  end

  assign tx_ready = ~active_r;
  assign tx       = tx_r;

endmodule

// File: rtl/rom_dump_uart.sv
// Sweeps the ROM reader address space and prints every address/data pair as
// an ASCII hex record ("AAA:DD\r\n") over an 8N1 UART.
module rom_dump_uart
  import rom_dump_uart_pkg::*;
#(
  parameter int DATA_WIDTH    = IP3604_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = IP3604_ADDRESS_WIDTH,
  parameter int CLK_DIV       = 434,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  rom_dump_uart_if.master rd,
  output logic            uart_tx,
  output logic            busy,
  output logic            done
);
  localparam int AD      = (ADDRESS_WIDTH + 3) / 4;
  localparam int DD      = (DATA_WIDTH + 3) / 4;
  localparam int AXW     = AD * 4;
  localparam int DXW     = DD * 4;
  localparam int REC_LEN = AD + DD + 3;
  localparam int CW      = $clog2(REC_LEN);
  localparam int TW      = $clog2(SETTLE_CYCLES) + 1;

  localparam logic [CW-1:0] IDX_COLON = CW'(AD);
  localparam logic [CW-1:0] IDX_CR    = CW'(AD + 1 + DD);
  localparam logic [CW-1:0] IDX_LF    = CW'(REC_LEN - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] STEP_LAST   = TW'(1);
  localparam logic [ADDRESS_WIDTH:0] CNT_END = {1'b1, {ADDRESS_WIDTH{1'b0}}};

  dump_state_e          state_r, state_nx_s;
  logic [TW-1:0]        timer_r, timer_nx_s;
  logic [CW-1:0]        char_idx_r, char_idx_nx_s;
  logic [ADDRESS_WIDTH:0] cnt_r, cnt_nx_s, cnt_inc_s;
  logic [AXW-1:0]       addr_sh_r, addr_sh_nx_s;
  logic [DXW-1:0]       data_sh_r, data_sh_nx_s;
  logic                 busy_r, busy_nx_s;
  logic                 done_r, done_nx_s;
  logic                 incr_r;
  logic                 tx_valid_s;
  logic                 tx_ready_s;
  logic [7:0]           tx_char_s;

  assign cnt_inc_s = cnt_r + (ADDRESS_WIDTH + 1)'(1'b1);

  // State, capture registers and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      timer_r    <= '0;
      char_idx_r <= '0;
      cnt_r      <= '0;
      addr_sh_r  <= '0;
      data_sh_r  <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      incr_r     <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      timer_r    <= timer_nx_s;
      char_idx_r <= char_idx_nx_s;
      cnt_r      <= cnt_nx_s;
      addr_sh_r  <= addr_sh_nx_s;
      data_sh_r  <= data_sh_nx_s;
      busy_r     <= busy_nx_s;
      done_r     <= done_nx_s;
      incr_r     <= (state_nx_s == ST_STEP_HI);
    end
  end

  // Next-state logic: settle, capture, send a record, then step the reader
  always_comb begin
    state_nx_s    = state_r;
    timer_nx_s    = timer_r;
    char_idx_nx_s = char_idx_r;
    cnt_nx_s      = cnt_r;
    addr_sh_nx_s  = addr_sh_r;
    data_sh_nx_s  = data_sh_r;
    busy_nx_s     = busy_r;
    done_nx_s     = done_r;
    tx_valid_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx_s = ST_SETTLE;
          timer_nx_s = '0;
          done_nx_s  = 1'b0;
          busy_nx_s  = 1'b1;
          cnt_nx_s   = '0;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (timer_r == SETTLE_LAST) begin
          state_nx_s = ST_CAPTURE;
        end else begin
          timer_nx_s = timer_r + TW'(1'b1);
        end
      end
      ST_CAPTURE: begin
        addr_sh_nx_s  = AXW'(rd.address_line);
        data_sh_nx_s  = DXW'(rd.data_line);
        char_idx_nx_s = '0;
        state_nx_s    = ST_SEND;
      end
      ST_SEND: begin
        tx_valid_s = 1'b1;
        if (tx_ready_s) begin
          // Shift the digit just accepted out of its capture register
          if (char_idx_r < IDX_COLON) begin
            addr_sh_nx_s = {addr_sh_r[AXW-5:0], 4'h0};
          end else if ((char_idx_r > IDX_COLON) && (char_idx_r < IDX_CR)) begin
            data_sh_nx_s = {data_sh_r[DXW-5:0], 4'h0};
          end else begin
            addr_sh_nx_s = addr_sh_r;
          end
          if (char_idx_r == IDX_LF) begin
            cnt_nx_s      = cnt_inc_s;
            char_idx_nx_s = '0;
            if (cnt_inc_s == CNT_END) begin
              state_nx_s = ST_WAIT_TX;
            end else begin
              state_nx_s = ST_STEP_HI;
              timer_nx_s = '0;
            end
          end else begin
            char_idx_nx_s = char_idx_r + CW'(1'b1);
          end
        end else begin
          state_nx_s = ST_SEND;
        end
      end
      ST_STEP_HI: begin
        if (timer_r == STEP_LAST) begin
          state_nx_s = ST_STEP_LO;
        end else begin
          timer_nx_s = timer_r + TW'(1'b1);
        end
      end
      ST_STEP_LO: begin
        state_nx_s = ST_SETTLE;
        timer_nx_s = '0;
      end
      ST_WAIT_TX: begin
        if (tx_ready_s) begin
          state_nx_s = ST_IDLE;
          done_nx_s  = 1'b1;
          busy_nx_s  = 1'b0;
        end else begin
          state_nx_s = ST_WAIT_TX;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Character mux: address digits, colon, data digits, CR, LF
  always_comb begin
    tx_char_s = ASCII_LF;
    if (char_idx_r < IDX_COLON) begin
      tx_char_s = hex_ascii(addr_sh_r[AXW-1 -: 4]);
    end else if (char_idx_r == IDX_COLON) begin
      tx_char_s = ASCII_COLON;
    end else if (char_idx_r < IDX_CR) begin
      tx_char_s = hex_ascii(data_sh_r[DXW-1 -: 4]);
    end else if (char_idx_r == IDX_CR) begin
      tx_char_s = ASCII_CR;
    end else begin
      tx_char_s = ASCII_LF;
    end
  end

  rom_dump_uart_tx #(.DIV(CLK_DIV)) u_tx (
    .clk      (clk),
    .reset_n  (reset_n),
    .tx_data  (tx_char_s),
    .tx_valid (tx_valid_s),
    .tx_ready (tx_ready_s),
    .tx       (uart_tx)
  );

  assign rd.increment_address = incr_r;
  assign busy                 = busy_r;
  assign done                 = done_r;

endmodule
